// File: rtl/wb_master_pkg.sv
// Shared types and constants for the Wishbone classic single-transfer initiator.
package wb_master_pkg;

  // Controller states: waiting for a command, running the bus cycle, holding the response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Default data width, and the byte-select width that goes with it.
  localparam int DAT_W_DEFAULT = 32;
  localparam int SEL_W         = DAT_W_DEFAULT / 8;

  // Response status as it appears on rsp_err_o.
  localparam logic RSP_OK      = 1'b0;
  localparam logic RSP_TIMEOUT = 1'b1;

  // Byte-select width for an arbitrary data width.
  function automatic int sel_width(input int dat_w);
    return dat_w / 8;
  endfunction

endpackage

// File: rtl/wb_timeout_timer.sv
// Counts cycles spent waiting for a Wishbone ack and flags when the wait budget is used up.
// expired_o is high while the count sits at TIMEOUT-1. The count stops there until cleared.
// With TIMEOUT=0 the timer is removed entirely and never expires.
module wb_timeout_timer
  import wb_master_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk_i, rst_i, clear_i, enable_i};
      assign expired_o     = 1'b0;
    end else begin : g_on
      localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

      logic [CW-1:0] count_q;
      logic [CW-1:0] count_d;

      // Clear has priority; otherwise count up while enabled and stop at the last value.
      always_comb begin
        count_d = count_q;
        if (clear_i) begin
          count_d = '0;
        end else if (enable_i && (count_q != LAST)) begin
          count_d = count_q + CW'(1);
        end
      end

      // Count register; async reset returns it to zero.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          count_q <= '0;
        end else begin
          count_q <= count_d;
        end
      end

      assign expired_o = (count_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/wb_master_seq.sv
// Wishbone B3 classic initiator with one transfer in flight at a time.
// It accepts a command over valid/ready, runs one read or write cycle, and returns the data and status over valid/ready.
// A no-ack timeout aborts a stalled cycle. Transfer and error counters wrap.
module wb_master_seq
  import wb_master_pkg::*;
#(
  parameter int ADR_W   = 32,
  parameter int DAT_W   = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_we_i,
  input  logic [ADR_W-1:0]   cmd_adr_i,
  input  logic [DAT_W-1:0]   cmd_dat_i,
  input  logic [DAT_W/8-1:0] cmd_sel_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [DAT_W-1:0]   rsp_dat_o,
  output logic               rsp_err_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic               wbm_we_o,
  output logic [DAT_W/8-1:0] wbm_sel_o,
  output logic [ADR_W-1:0]   wbm_adr_o,
  output logic [DAT_W-1:0]   wbm_dat_o,
  input  logic [DAT_W-1:0]   wbm_dat_i,
  input  logic               wbm_ack_i,
  output logic [CNT_W-1:0]   xfer_cnt_o,
  output logic [CNT_W-1:0]   err_cnt_o
);

  state_t state_q, state_d;

  logic               cyc_q, cyc_d;
  logic               stb_q, stb_d;
  logic               we_q, we_d;
  logic [DAT_W/8-1:0] sel_q, sel_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [DAT_W-1:0]   dat_q, dat_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DAT_W-1:0]   rsp_dat_q, rsp_dat_d;
  logic               rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]   xfer_cnt_q, xfer_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic cmd_accept;
  logic bus_ack;
  logic bus_timeout;
  logic timer_expired;

  // A command is taken only while idle. An ack counts only while our cycle is open.
  // A timeout counts only when no ack arrives in the same cycle, so an ack always wins.
  assign cmd_accept  = (state_q == IDLE) && cmd_valid_i;
  assign bus_ack     = (state_q == BUS) && cyc_q && wbm_ack_i;
  assign bus_timeout = (state_q == BUS) && !wbm_ack_i && timer_expired;

  wb_timeout_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .clear_i   (cmd_accept),
    .enable_i  (state_q == BUS),
    .expired_o (timer_expired)
  );

  // State register with async reset back to IDLE.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: IDLE -> BUS on accept, BUS -> RESP on ack or timeout, RESP -> IDLE on consume.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cmd_valid_i) state_d = BUS;
      BUS:  if (bus_ack || bus_timeout) state_d = RESP;
      RESP: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs. The bus fields hold their last values outside BUS.
  always_comb begin
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    xfer_cnt_d  = xfer_cnt_q;
    err_cnt_d   = err_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          we_d  = cmd_we_i;
          sel_d = cmd_sel_i;
          adr_d = cmd_adr_i;
          dat_d = cmd_dat_i;
          cyc_d = 1'b1;
          stb_d = 1'b1;
        end
      end
      BUS: begin
        if (bus_ack) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = we_q ? '0 : wbm_dat_i;
          rsp_err_d   = RSP_OK;
          xfer_cnt_d  = xfer_cnt_q + CNT_W'(1);
        end else if (bus_timeout) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = '0;
          rsp_err_d   = RSP_TIMEOUT;
          err_cnt_d   = err_cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        cyc_d       = 1'b0;
        stb_d       = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // Output and counter registers. Async reset drops the bus immediately and clears everything.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= RSP_OK;
      xfer_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      xfer_cnt_q  <= xfer_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = stb_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign xfer_cnt_o  = xfer_cnt_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: doc/wb_master_seq.md
Name: wb_master_seq

Overview:
- Wishbone classic (B3, non-pipelined) initiator, single outstanding transfer.
- Takes one command at a time over a valid/ready interface and runs one read or write cycle on the Wishbone bus.
- Returns read data and a status over a valid/ready response channel.
- Used by user-area logic and benches to drive Wishbone responders such as the counter slave; includes a no-ack timeout and transfer/error counters.

Parameters:
- ADR_W, 32, Wishbone address width.
- DAT_W, 32, Wishbone data width; must be a multiple of 8.
- TIMEOUT, 255, cycles to wait for ack before aborting; 0 disables the timeout.
- CNT_W, 16, width of the transfer and error counters.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when valid&&ready.
- cmd_we_i  in  1  1=write, 0=read.
- cmd_adr_i  in  ADR_W  address.
- cmd_dat_i  in  DAT_W  write data.
- cmd_sel_i  in  DAT_W/8  byte selects.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed when valid&&ready.
- rsp_dat_o  out  DAT_W  read data; 0 for writes and timeouts.
- rsp_err_o  out  1  1=timeout abort.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_sel_o  out  DAT_W/8  Wishbone byte selects.
- wbm_adr_o  out  ADR_W  Wishbone address.
- wbm_dat_o  out  DAT_W  Wishbone write data.
- wbm_dat_i  in  DAT_W  Wishbone read data.
- wbm_ack_i  in  1  Wishbone acknowledge.
- xfer_cnt_o  out  CNT_W  completed (acked) transfers.
- err_cnt_o  out  CNT_W  timeouts.

Behaviour:
- All outputs are registered except cmd_ready_o, which equals (state==IDLE).
- Reset (async assert, sync release): state=IDLE; cyc/stb/we=0; sel/adr/dat_o=0; rsp_valid=0; rsp_dat=0; rsp_err=0; counters=0.
- State IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i: latch we/adr/dat/sel into wbm_* registers, set cyc=stb=1, clear the timer, go to BUS.
  - Bus activity starts the cycle after acceptance.
- State BUS:
  - cyc=stb=1; wbm_* held constant.
  - Timer increments each cycle.
  - On wbm_ack_i:
    - capture rsp_dat = we ? 0 : wbm_dat_i;
    - rsp_err=0; drop cyc/stb on the same edge;
    - xfer_cnt+1; go to RESP.
  - If TIMEOUT!=0, no ack, and the timer has reached TIMEOUT-1:
    - drop cyc/stb; rsp_dat=0; rsp_err=1;
    - err_cnt+1; go to RESP.
  - Ack and timeout in the same cycle: ack wins.
  - Only one ack is consumed per cycle; cyc/stb are low in the following cycle, so a back-to-back slave ack cannot double-complete.
- State RESP:
  - rsp_valid=1; rsp_dat/rsp_err held.
  - On rsp_ready_i: rsp_valid=0, go to IDLE.
  - No command is accepted in RESP.
- wbm_ack_i while cyc=0 is ignored.
- Latency:
  - Command accepted at edge 0 → cyc/stb high from cycle 1.
  - Ack sampled at edge k → rsp_valid high from cycle k+1.
  - Minimum command-to-response is 2 cycles.
  - Throughput is one transfer per 3 cycles minimum (IDLE, BUS, RESP).
- Counters wrap modulo 2^CNT_W.
- Reset mid-BUS: cyc/stb drop asynchronously; the pending command is lost and counters clear.
- wbm_we_o/sel/adr/dat_o keep their last values outside BUS.

Decomposition:
- Package wb_master_pkg holds:
  - state enum {IDLE, BUS, RESP};
  - localparam SEL_W = DAT_W/8;
  - status codes RSP_OK=0, RSP_TIMEOUT=1.
- One sub-module, wb_timeout_timer (parameter TIMEOUT):
  - inputs: clk, async reset, clear, enable;
  - output: expired;
  - tied off (expired=0) when TIMEOUT=0.

Test Plan:
- Write: cmd we=1 adr=0x3000_0000 dat=0xDEAD_BEEF sel=0xF; slave acks 2 cycles after stb → bus shows those values with cyc/stb high exactly 3 cycles; rsp_valid, rsp_err=0, rsp_dat=0; xfer_cnt=1.
- Read: slave returns 0x1234_5678 with ack on the first stb cycle → rsp_dat=0x1234_5678 one cycle later; cyc/stb high exactly 1 cycle.
- Timeout: TIMEOUT=8, slave never acks → cyc/stb drop after 8 cycles; rsp_err=1, rsp_dat=0, err_cnt=1; a following acked read succeeds.
- Backpressure: hold rsp_ready_i=0 for 5 cycles → rsp_valid/rsp_dat stable; cmd_ready_o=0 throughout; no new bus cycle starts.
- Ack coincides with timeout (TIMEOUT=4, ack on 4th stb cycle) → rsp_err=0, xfer_cnt+1, err_cnt unchanged.
- Async reset asserted mid-BUS between clock edges → cyc/stb/rsp_valid=0 immediately; state IDLE and cmd_ready_o=1 after release; counters 0.
